// File: rtl/game_tick_pkg.sv
// Shared definitions for the Pong tick scheduler.
//   state_t          : 2-bit game phase encoding (IDLE, SERVE, RUN, PAUSE)
//   CFG_*            : cfg_addr register map
//   DEF_*            : reset values of the period and serve-delay registers
//   period_hit()     : ">= with zero treated as one" compare shared by all counters
package game_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [1:0] CFG_BALL  = 2'd0;
  localparam logic [1:0] CFG_PAD   = 2'd1;
  localparam logic [1:0] CFG_BLINK = 2'd2;
  localparam logic [1:0] CFG_SERVE = 2'd3;

  localparam int DEF_BALL  = 4;
  localparam int DEF_PAD   = 2;
  localparam int DEF_BLINK = 16;
  localparam int DEF_SERVE = 32;

  // True when one more count reaches the period. A period of 0 behaves as 1,
  // and the >= compare means a period shrunk below the count fires at once.
  function automatic logic period_hit(input logic [31:0] c, input logic [31:0] p);
    logic [32:0] lim;
    lim = (p == 32'd0) ? 33'd1 : {1'b0, p};
    return ({1'b0, c} + 33'd1) >= lim;
  endfunction

endpackage

// File: rtl/game_tick_sched_tick_chan.sv
// tick_chan: one tick channel of the scheduler.
// Holds a run-time programmable period, a counter advanced on enabled base
// ticks, and a registered single-cycle tick pulse.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   en              channel enabled in the current game phase
//   base_tick       prescaled base tick
//   clr             clear the counter (takes precedence, suppresses the tick)
//   wr, wdata       period register write
//   tick            1-cycle enable, one clk after the qualifying base tick
module tick_chan
  import game_tick_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEF   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             base_tick,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  output logic             tick
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic             fire;

  // The compare uses the period held before this edge, so a write landing on
  // a firing base tick only takes effect from the following tick.
  assign fire = en & base_tick & period_hit(32'(cnt), 32'(period));

  // Stage boundary: counter/period update and registered tick pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period <= CNT_W'(DEF);
      cnt    <= '0;
      tick   <= 1'b0;
    end else begin
      if (wr) period <= wdata;
      tick <= fire & ~clr;
      if (clr)
        cnt <= '0;
      else if (en & base_tick)
        cnt <= fire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_tick_sched.sv
// game_tick_sched: central tick scheduler for the Pong datapath.
// Prescales clk into a base tick, sequences the game phases and derives the
// ball, paddle and blink enables from three tick_chan instances.
// Optional build macro: GAME_TICK_STEP_EN (single-step ball/paddle in PAUSE).
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 pulse, IDLE -> SERVE
//   pause                 level, freeze the game while high
//   serve_req             pulse, point scored, RUN -> SERVE
//   step                  pulse, single step in PAUSE (macro builds only)
//   cfg_we/addr/data      period register writes (0 ball,1 paddle,2 blink,3 serve)
//   ball_tick, paddle_tick, blink_tick   1-cycle enables
//   serve_done            pulse when the serve delay expires
//   state                 0 IDLE, 1 SERVE, 2 RUN, 3 PAUSE
module game_tick_sched
  import game_tick_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int CNT_W     = 8,
  parameter int BALL_DEF  = DEF_BALL,
  parameter int PAD_DEF   = DEF_PAD,
  parameter int BLINK_DEF = DEF_BLINK,
  parameter int SERVE_DEF = DEF_SERVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             serve_req,
  input  logic             step,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             ball_tick,
  output logic             paddle_tick,
  output logic             blink_tick,
  output logic             serve_done,
  output logic [1:0]       state
);

  logic [15:0]      pre;
  logic             base_tick;
  state_t           st, st_nxt, ret, ret_nxt;
  logic [CNT_W-1:0] srv_delay, srv_cnt;
  logic             srv_en, serve_fire, srv_clr;
  logic             ball_en, pad_en, blink_en, ball_clr;
  logic             ball_raw, pad_raw;

  assign base_tick = (pre == 16'(PRESCALE - 1));

  // Stage boundary: free-running prescaler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre <= '0;
    else        pre <= base_tick ? '0 : pre + 16'd1;
  end

  // pause freezes the game-side counters in the very cycle it is seen, before
  // the state register has moved to PAUSE.
  assign ball_en  = (st == ST_RUN) & ~pause;
  assign pad_en   = ((st == ST_SERVE) | (st == ST_RUN)) & ~pause;
  assign blink_en = (st == ST_IDLE) | (st == ST_PAUSE);
  assign srv_en   = (st == ST_SERVE) & ~pause;

  assign serve_fire = srv_en & base_tick & period_hit(32'(srv_cnt), 32'(srv_delay));

  // Priority: pause > serve_req > serve expiry.
  always_comb begin
    st_nxt   = st;
    ret_nxt  = ret;
    srv_clr  = 1'b0;
    ball_clr = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start) begin
          st_nxt  = ST_SERVE;
          srv_clr = 1'b1;
        end
      end
      ST_SERVE: begin
        if (pause) begin
          st_nxt  = ST_PAUSE;
          ret_nxt = ST_SERVE;
        end else if (serve_fire) begin
          st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pause) begin
          st_nxt  = ST_PAUSE;
          ret_nxt = ST_RUN;
        end else if (serve_req) begin
          st_nxt   = ST_SERVE;
          srv_clr  = 1'b1;
          ball_clr = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!pause) st_nxt = ret;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Stage boundary: phase register, serve delay counter and serve_done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      ret        <= ST_IDLE;
      srv_delay  <= CNT_W'(SERVE_DEF);
      srv_cnt    <= '0;
      serve_done <= 1'b0;
    end else begin
      st         <= st_nxt;
      ret        <= ret_nxt;
      serve_done <= serve_fire;
      if (cfg_we && cfg_addr == CFG_SERVE) srv_delay <= cfg_data;
      if (srv_clr)
        srv_cnt <= '0;
      else if (srv_en & base_tick)
        srv_cnt <= serve_fire ? '0 : srv_cnt + 1'b1;
    end
  end

  assign state = st;

  tick_chan #(.CNT_W(CNT_W), .DEF(BALL_DEF)) u_ball (
    .clk       (clk),
    .reset     (reset),
    .en        (ball_en),
    .base_tick (base_tick),
    .clr       (ball_clr),
    .wr        (cfg_we && cfg_addr == CFG_BALL),
    .wdata     (cfg_data),
    .tick      (ball_raw)
  );

  tick_chan #(.CNT_W(CNT_W), .DEF(PAD_DEF)) u_pad (
    .clk       (clk),
    .reset     (reset),
    .en        (pad_en),
    .base_tick (base_tick),
    .clr       (1'b0),
    .wr        (cfg_we && cfg_addr == CFG_PAD),
    .wdata     (cfg_data),
    .tick      (pad_raw)
  );

  tick_chan #(.CNT_W(CNT_W), .DEF(BLINK_DEF)) u_blink (
    .clk       (clk),
    .reset     (reset),
    .en        (blink_en),
    .base_tick (base_tick),
    .clr       (1'b0),
    .wr        (cfg_we && cfg_addr == CFG_BLINK),
    .wdata     (cfg_data),
    .tick      (blink_tick)
  );

`ifdef GAME_TICK_STEP_EN
  logic step_tick_p1;

  // Stage boundary: step pulse, only honoured in PAUSE where the ball and
  // paddle channels are idle, so it never collides with a channel tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_tick_p1 <= 1'b0;
    else        step_tick_p1 <= step & (st == ST_PAUSE);
  end

  assign ball_tick   = ball_raw | step_tick_p1;
  assign paddle_tick = pad_raw | step_tick_p1;
`else
  logic unused_step;
  assign unused_step = step;
  assign ball_tick   = ball_raw;
  assign paddle_tick = pad_raw;
`endif

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched (PRESCALE = 4, default periods).
// Directed phases follow the game flow; a randomized phase compares every
// cycle against a behavioural model of the scheduler rules.
module tb_game_tick_sched;

  localparam int PRESCALE = 4;
`ifdef GAME_TICK_STEP_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start, pause, serve_req, step, cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       ball_tick, paddle_tick, blink_tick, serve_done;
  logic [1:0] state;

  game_tick_sched #(.PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .serve_req   (serve_req),
    .step        (step),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ball_tick   (ball_tick),
    .paddle_tick (paddle_tick),
    .blink_tick  (blink_tick),
    .serve_done  (serve_done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: indices 0 ball, 1 paddle, 2 blink, 3 serve delay.
  int m_pre, m_st, m_ret;
  int m_p[4];
  int m_c[4];
  bit m_ball, m_pad, m_blink, m_done;

  int last_ball, last_pad, last_blink;
  int ball_gap, pad_gap, blink_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit reaches(input int c, input int p);
    return (c + 1) >= ((p == 0) ? 1 : p);
  endfunction

  task automatic model_reset();
    m_pre = 0; m_st = 0; m_ret = 0;
    m_p = '{4, 2, 16, 32};
    m_c = '{0, 0, 0, 0};
    m_ball = 0; m_pad = 0; m_blink = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit base;
    bit en[4];
    bit f[4];
    bit drop_ball;
    int nst;
    base  = (m_pre == PRESCALE - 1);
    en[0] = (m_st == 2) && !pause;
    en[1] = (m_st == 1 || m_st == 2) && !pause;
    en[2] = (m_st == 0 || m_st == 3);
    en[3] = (m_st == 1) && !pause;
    for (int i = 0; i < 4; i++) begin
      f[i] = 0;
      if (base && en[i]) begin
        if (reaches(m_c[i], m_p[i])) begin f[i] = 1; m_c[i] = 0; end
        else m_c[i] = m_c[i] + 1;
      end
    end
    drop_ball = 0;
    nst = m_st;
    if (m_st == 0) begin
      if (start) begin nst = 1; m_c[3] = 0; end
    end else if (m_st == 1 || m_st == 2) begin
      if (pause) begin nst = 3; m_ret = m_st; end
      else if (m_st == 1 && f[3]) nst = 2;
      else if (m_st == 2 && serve_req) begin nst = 1; m_c[3] = 0; m_c[0] = 0; drop_ball = 1; end
    end else begin
      if (!pause) nst = m_ret;
    end
    m_ball  = f[0] && !drop_ball;
    m_pad   = f[1];
    m_blink = f[2];
    m_done  = f[3];
    if (STEP_EN && m_st == 3 && step) begin m_ball = 1; m_pad = 1; end
    m_st = nst;
    if (cfg_we) m_p[cfg_addr] = int'(cfg_data);
    m_pre = base ? 0 : m_pre + 1;
  endtask

  task automatic check_all();
    chk("ball_tick",   {31'd0, ball_tick},   {31'd0, m_ball});
    chk("paddle_tick", {31'd0, paddle_tick}, {31'd0, m_pad});
    chk("blink_tick",  {31'd0, blink_tick},  {31'd0, m_blink});
    chk("serve_done",  {31'd0, serve_done},  {31'd0, m_done});
    chk("state",       {30'd0, state},       m_st);
  endtask

  task automatic reset_gaps();
    last_ball = -1; last_pad = -1; last_blink = -1;
    ball_gap = 0; pad_gap = 0; blink_gap = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    cyc++;
    check_all();
    if (ball_tick)  begin if (last_ball  >= 0) ball_gap  = cyc - last_ball;  last_ball  = cyc; end
    if (paddle_tick) begin if (last_pad  >= 0) pad_gap   = cyc - last_pad;   last_pad   = cyc; end
    if (blink_tick) begin if (last_blink >= 0) blink_gap = cyc - last_blink; last_blink = cyc; end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic wait_ball(output int n);
    n = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (ball_tick) begin n = i; break; end
    end
  endtask

  initial begin
    int n1, n2, cnt;
    reset = 0; start = 0; pause = 0; serve_req = 0; step = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    model_reset();
    reset_gaps();

    // Reset state
    repeat (3) tick();
    reset = 1;

    // IDLE: blink only, every 64 clk
    reset_gaps();
    repeat (140) tick();
    chk("idle_blink_gap", blink_gap, 64);
    chk("idle_no_ball", last_ball, -1);

    // Serve delay 2, ball period 3, then start
    cfg_write(2'd3, 8'd2);
    cfg_write(2'd0, 8'd3);
    start = 1; tick(); start = 0;
    chk("state_after_start", {30'd0, state}, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (serve_done) cnt++; end
    chk("serve_done_once", cnt, 1);
    chk("state_run", {30'd0, state}, 2);
    reset_gaps();
    repeat (60) tick();
    chk("ball_gap_12", ball_gap, 12);
    chk("pad_gap_8", pad_gap, 8);

    // Pause 20 clk in RUN
    pause = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (ball_tick || paddle_tick) cnt++; end
    chk("pause_state", {30'd0, state}, 3);
    chk("pause_no_game_ticks", cnt, 0);
    pause = 0; tick();
    chk("pause_release_state", {30'd0, state}, 2);

    // Shrink ball period from 3 to 1 while C = 2
    cnt = 0;
    while (!(m_c[0] == 2 && m_pre == 0) && cnt < 64) begin tick(); cnt++; end
    chk("reach_c2_bound", {31'd0, cnt < 64}, 1);
    cfg_write(2'd0, 8'd1);
    wait_ball(n1);
    chk("shrink_fires_next_base", {31'd0, n1 > 0 && n1 <= 4}, 1);
    wait_ball(n2);
    chk("shrink_gap_4", n2, 4);

    // serve_req coinciding with pause is dropped
    serve_req = 1; pause = 1; tick(); serve_req = 0;
    chk("sreq_pause_state", {30'd0, state}, 3);
    repeat (5) tick();
    pause = 0; tick();
    chk("sreq_pause_return", {30'd0, state}, 2);

    // step in PAUSE, then in RUN
    pause = 1; repeat (3) tick();
    step = 1; tick(); step = 0;
    chk("step_ball", {31'd0, ball_tick}, {31'd0, STEP_EN});
    chk("step_paddle", {31'd0, paddle_tick}, {31'd0, STEP_EN});
    pause = 0; repeat (2) tick();
    step = 1; tick(); step = 0;
    repeat (4) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 16) == 0;
      serve_req = ($urandom % 20) == 0;
      step      = ($urandom % 8) == 0;
      if (($urandom % 25) == 0) pause = ~pause;
      cfg_we    = ($urandom % 10) == 0;
      cfg_addr  = 2'($urandom % 4);
      cfg_data  = 8'($urandom % 7);
      tick();
    end
    start = 0; serve_req = 0; step = 0; pause = 0; cfg_we = 0;

    // Normalise, then reset asynchronously mid-SERVE
    reset = 0; repeat (2) tick();
    reset = 1; tick();
    start = 1; tick(); start = 0;
    repeat (30) tick();
    chk("mid_serve_state", {30'd0, state}, 1);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_ball", {31'd0, ball_tick}, 0);
    chk("async_paddle", {31'd0, paddle_tick}, 0);
    chk("async_blink", {31'd0, blink_tick}, 0);
    chk("async_done", {31'd0, serve_done}, 0);
    chk("async_state", {30'd0, state}, 0);
    repeat (2) tick();
    reset = 1;
    reset_gaps();
    repeat (140) tick();
    chk("post_reset_state", {30'd0, state}, 0);
    chk("post_reset_blink_gap", blink_gap, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_tick_sched.md
Name: game_tick_sched

Overview:
- Central tick scheduler for the Pong datapath. Prescales the system clock into a base tick, then derives per-consumer single-cycle enables: ball motion, paddle motion, and score/pause blink.
- Sequences game phases (idle, serve delay, run, pause) and gates each enable accordingly.
- Periods are written at run time by the game-control logic through a small configuration port.

Parameters:
- PRESCALE, 4: clk cycles per base tick; legal range 2 to 2^16-1.
- CNT_W, 8: width of period registers and channel counters.
- BALL_DEF, 4: reset value of the ball period, in base ticks.
- PAD_DEF, 2: reset value of the paddle period, in base ticks.
- BLINK_DEF, 16: reset value of the blink period, in base ticks.
- SERVE_DEF, 32: reset value of the serve delay, in base ticks.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; leave IDLE and begin serve
- pause  in  1  level; hold game frozen while high
- serve_req  in  1  1-cycle pulse; point scored, re-enter serve delay
- step  in  1  1-cycle pulse; single-step while paused (optional feature only)
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  2  0 = ball period, 1 = paddle period, 2 = blink period, 3 = serve delay
- cfg_data  in  CNT_W  write data
- ball_tick  out  1  1-cycle enable to ball logic
- paddle_tick  out  1  1-cycle enable to paddle logic
- blink_tick  out  1  1-cycle enable to blink logic
- serve_done  out  1  1-cycle pulse when serve delay expires
- state  out  2  0 = IDLE, 1 = SERVE, 2 = RUN, 3 = PAUSE

Behaviour:
- Reset (reset = 0, async)
  - All outputs 0; state = IDLE.
  - Prescaler and all counters = 0.
  - Period registers load the *_DEF values.
- Prescaler
  - Free-runs in every state, 0..PRESCALE-1.
  - base_tick is internal and high in the cycle the prescaler equals PRESCALE-1.
- Channels
  - Each channel has a period register P and a counter C. A period of 0 is treated as 1.
  - On base_tick, if the channel is enabled: if C+1 >= P, C goes to 0 and the tick output is registered high for exactly 1 clk in the next cycle; otherwise C increments.
  - Because the compare is >=, shrinking P below C fires on the next enabled base_tick; there is no lock-up.
  - Channel enables by state:
    - ball: RUN only.
    - paddle: SERVE and RUN.
    - blink: IDLE and PAUSE.
  - A disabled channel holds C; it is not cleared.
- Configuration
  - cfg_we writes the addressed register at the clock edge.
  - The new value is used from the next cycle.
  - A write coinciding with a channel's firing base_tick uses the old P for that tick.
- FSM, evaluated every clk
  - IDLE: start goes to SERVE and clears the serve counter.
  - SERVE: counts enabled base ticks. When the count reaches the serve delay (delay 0 treated as 1), pulse serve_done and go to RUN.
  - RUN: serve_req goes to SERVE, clearing the serve counter and the ball C.
  - PAUSE: pause high in SERVE or RUN goes to PAUSE and stores the return state. While pause is high, the serve counter, ball C and paddle C are frozen. When pause falls, return to the stored state with counters intact.
  - Priority: pause > serve_req > serve expiry. A serve_req during PAUSE is dropped. start outside IDLE is ignored.
- Latency
  - A tick output rises 1 clk after the qualifying base_tick.
  - The state change is visible 1 clk after its cause.

Optional Feature:
- GAME_TICK_STEP_EN defined:
  - In PAUSE, a step pulse produces one ball_tick and one paddle_tick together, 1 clk later. C registers are untouched.
  - step outside PAUSE is ignored.
- Undefined: the step port exists but is ignored, and no step logic is synthesized.

Decomposition:
- Package game_tick_pkg holds:
  - the 2-bit state encoding constants,
  - the cfg_addr constants (CFG_BALL, CFG_PAD, CFG_BLINK, CFG_SERVE),
  - the default period constants.
- Sub-module tick_chan: period register, counter, >= compare and registered pulse, with inputs en, base_tick, clr, wr and wdata. It is instantiated three times; the FSM and prescaler live in the top.

Test Plan (PRESCALE = 4):
- Reset released, no start → blink_tick every 64 clk (16 base ticks × 4); ball_tick and paddle_tick stay 0; state = 0.
- Write serve delay 2 and ball period 3, then start → state = 1; paddle_tick every 8 clk; serve_done exactly once, at the 2nd base tick after start; then state = 2; ball_tick every 12 clk.
- In RUN, hold pause 20 clk → state = 3; no ball or paddle ticks; blink ticks resume. On release, state = 2 and the next ball_tick lands at its original phase, offset by exactly the pause length rounded to whole base ticks.
- In RUN with ball C = 2 and P = 3, write P = 1 → ball_tick on the next base tick; thereafter every 4 clk.
- serve_req and pause asserted in the same cycle → state = 3 and serve_req is dropped; on release, state = 2.
- Assert reset mid-SERVE → all outputs 0 immediately; after release, state = 0 and periods are back at their defaults.
- With GAME_TICK_STEP_EN defined: step in PAUSE → ball_tick and paddle_tick together 1 clk later; step in RUN → no extra tick.
